vdp_timing_ctrl_g4567: RTL and testbench

Bitmap-mode fetch and pixel-timing engine for the V9958-compatible VDP, covering Graphic4–7 (SCREEN5/6/7/8). It sits between the screen timing generator, which supplies position counters, and the VRAM arbiter. It issues 32-bit VRAM read requests at fixed slots of each 64-clock (8-dot) block. It serializes the returned words into one palette index per clock on `display_color`.

---
 rtl/vdp_package.sv | 33 +++
 rtl/vdp_g4567_dot_selector.sv | 47 ++++
 rtl/vdp_timing_ctrl_g4567.sv | 142 ++++++++++++++
 tb/tb_vdp_timing_ctrl_g4567.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_package.sv
// Shared constants and mode decoding for the bitmap-mode (Graphic4..7) VDP fetch/display path.
package vdp_package;

    localparam logic [4:0] c_mode_g4 = 5'b01100;
    localparam logic [4:0] c_mode_g5 = 5'b10000;
    localparam logic [4:0] c_mode_g6 = 5'b10100;
    localparam logic [4:0] c_mode_g7 = 5'b11100;

    localparam logic [5:0] c_phase_word0 = 6'd32;
    localparam logic [5:0] c_phase_word1 = 6'd40;
    localparam logic [5:0] c_phase_swap  = 6'd63;

    typedef enum logic [2:0] {
        BMP_NONE = 3'd0,
        BMP_G4   = 3'd1,
        BMP_G5   = 3'd2,
        BMP_G6   = 3'd3,
        BMP_G7   = 3'd4
    } bmp_mode_e;

    function automatic bmp_mode_e decode_mode(input logic [4:0] screen_mode);
        bmp_mode_e m;
        case (screen_mode)
            c_mode_g4: m = BMP_G4;
            c_mode_g5: m = BMP_G5;
            c_mode_g6: m = BMP_G6;
            c_mode_g7: m = BMP_G7;
            default:   m = BMP_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vdp_g4567_dot_selector.sv
// Picks one palette index out of a 64-bit fetched group (bytes ascending, left dot in high bits).
module vdp_g4567_dot_selector
    import vdp_package::*;
(
    input  logic [2:0]  mode_sel,
    input  logic [63:0] group_data,
    input  logic [2:0]  dot_idx,
    input  logic        half_sel,
    output logic [7:0]  color
);
    logic [7:0] group_bytes [8];
    logic [3:0] half_idx;
    logic [2:0] byte_idx;
    logic [7:0] sel_byte;
    logic [1:0] sel_pair;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bytes
            assign group_bytes[gi] = group_data[gi*8 +: 8];
        end
    endgenerate

    // High-resolution modes address half-dots: dot index plus the half-dot phase bit.
    assign half_idx = {dot_idx, half_sel};

    always_comb begin
        byte_idx = dot_idx;
        color    = 8'h00;
        case (mode_sel)
            BMP_G4:  byte_idx = {1'b0, dot_idx[2:1]};
            BMP_G5:  byte_idx = {1'b0, half_idx[3:2]};
            BMP_G6:  byte_idx = half_idx[3:1];
            default: byte_idx = dot_idx;
        endcase
        sel_byte = group_bytes[byte_idx];
        sel_pair = sel_byte[{~half_idx[1:0], 1'b0} +: 2];
        case (mode_sel)
            BMP_G4:  color = {4'h0, dot_idx[0] ? sel_byte[3:0] : sel_byte[7:4]};
            BMP_G5:  color = {6'h00, sel_pair};
            BMP_G6:  color = {4'h0, half_idx[0] ? sel_byte[3:0] : sel_byte[7:4]};
            BMP_G7:  color = sel_byte;
            default: color = 8'h00;
        endcase
    end

endmodule

// File: rtl/vdp_timing_ctrl_g4567.sv
// Graphic4..7 VRAM fetch slot generator and per-clock dot serializer.
// Define VDP_G4567_HSCROLL_EN to enable fine horizontal scroll (adds the previous-group register).
module vdp_timing_ctrl_g4567
    import vdp_package::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [12:0] screen_pos_x,
    input  logic [8:0]  pixel_pos_x,
    input  logic [7:0]  pixel_pos_y,
    input  logic        screen_v_active,
    output logic [16:0] vram_address,
    output logic        vram_valid,
    input  logic [31:0] vram_rdata,
    output logic [7:0]  display_color,
    input  logic [2:0]  horizontal_offset_l,
    input  logic [4:0]  reg_screen_mode,
    input  logic        reg_display_on,
    input  logic [6:0]  reg_pattern_name_table_base,
    input  logic [7:0]  reg_backdrop_color
);
    bmp_mode_e   mode;
    logic [2:0]  mode_bits;
    logic        supported;
    logic        two_word;
    logic        slot_hit;
    logic [5:0]  phase;
    logic [5:0]  group_idx;
    logic [2:0]  scroll;
    logic [3:0]  elem;
    logic [63:0] group_sel;
    logic [7:0]  dot_color;
    logic        unused_bits;

    logic        vram_valid_q, vram_valid_d;
    logic [16:0] vram_address_q, vram_address_d;
    logic [7:0]  display_color_q, display_color_d;
    logic [63:0] pend_q, pend_d;
    logic [63:0] cur_q, cur_d;
`ifdef VDP_G4567_HSCROLL_EN
    logic [63:0] prev_q, prev_d;
`endif

    assign mode      = decode_mode(reg_screen_mode);
    assign mode_bits = mode;
    assign supported = (mode != BMP_NONE);
    assign two_word  = (mode == BMP_G6) || (mode == BMP_G7);
    assign phase     = screen_pos_x[5:0];
    assign group_idx = pixel_pos_x[8:3] + 6'd1;
    assign slot_hit  = (phase[2:0] == 3'd0) &&
                       ((phase[5:3] == 3'd0) || (two_word && (phase[5:3] == 3'd1)));

`ifdef VDP_G4567_HSCROLL_EN
    assign scroll      = horizontal_offset_l;
    assign unused_bits = ^{screen_pos_x[12:6], group_idx[5], reg_pattern_name_table_base[4:0]};
`else
    assign scroll      = 3'd0;
    assign unused_bits = ^{screen_pos_x[12:6], group_idx[5], reg_pattern_name_table_base[4:0],
                           horizontal_offset_l, elem[3]};
`endif

    // Element 0..7 lives in the previous group, 8..15 in the current one.
    assign elem = 4'd8 + {1'b0, pixel_pos_x[2:0]} - {1'b0, scroll};

`ifdef VDP_G4567_HSCROLL_EN
    assign group_sel = elem[3] ? cur_q : prev_q;
`else
    assign group_sel = cur_q;
`endif

    vdp_g4567_dot_selector u_dot_selector (
        .mode_sel   (mode_bits),
        .group_data (group_sel),
        .dot_idx    (elem[2:0]),
        .half_sel   (screen_pos_x[2]),
        .color      (dot_color)
    );

    always_comb begin
        vram_valid_d   = 1'b0;
        vram_address_d = vram_address_q;
        if (screen_v_active && supported && slot_hit) begin
            vram_valid_d = 1'b1;
            if (two_word)
                vram_address_d = {reg_pattern_name_table_base[6], pixel_pos_y,
                                  group_idx[4:0], phase[3], 2'b00};
            else
                vram_address_d = {reg_pattern_name_table_base[6:5], pixel_pos_y,
                                  group_idx[4:0], 2'b00};
        end
    end

    // Returned words land in a pending buffer and only become visible at the block boundary.
    always_comb begin
        pend_d = pend_q;
        cur_d  = cur_q;
`ifdef VDP_G4567_HSCROLL_EN
        prev_d = prev_q;
`endif
        if (phase == c_phase_word0) pend_d[31:0]  = vram_rdata;
        if (phase == c_phase_word1) pend_d[63:32] = vram_rdata;
        if (phase == c_phase_swap) begin
            cur_d = pend_q;
`ifdef VDP_G4567_HSCROLL_EN
            prev_d = cur_q;
`endif
        end
    end

    always_comb begin
        display_color_d = reg_backdrop_color;
        if (screen_v_active && reg_display_on && !pixel_pos_x[8] && supported)
            display_color_d = dot_color;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_valid_q    <= 1'b0;
            vram_address_q  <= '0;
            display_color_q <= '0;
            pend_q          <= '0;
            cur_q           <= '0;
`ifdef VDP_G4567_HSCROLL_EN
            prev_q          <= '0;
`endif
        end else begin
            vram_valid_q    <= vram_valid_d;
            vram_address_q  <= vram_address_d;
            display_color_q <= display_color_d;
            pend_q          <= pend_d;
            cur_q           <= cur_d;
`ifdef VDP_G4567_HSCROLL_EN
            prev_q          <= prev_d;
`endif
        end
    end

    assign vram_valid    = vram_valid_q;
    assign vram_address  = vram_address_q;
    assign display_color = display_color_q;

endmodule

// File: tb/tb_vdp_timing_ctrl_g4567.sv
// Randomized scoreboard bench for vdp_timing_ctrl_g4567 against a dot-level reference model.
module tb_vdp_timing_ctrl_g4567;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] screen_pos_x;
    logic [8:0]  pixel_pos_x;
    logic [7:0]  pixel_pos_y;
    logic        screen_v_active;
    logic [16:0] vram_address;
    logic        vram_valid;
    logic [31:0] vram_rdata;
    logic [7:0]  display_color;
    logic [2:0]  horizontal_offset_l;
    logic [4:0]  reg_screen_mode;
    logic        reg_display_on;
    logic [6:0]  reg_pattern_name_table_base;
    logic [7:0]  reg_backdrop_color;

    always #5 clk = ~clk;

    vdp_timing_ctrl_g4567 dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .screen_pos_x                (screen_pos_x),
        .pixel_pos_x                 (pixel_pos_x),
        .pixel_pos_y                 (pixel_pos_y),
        .screen_v_active             (screen_v_active),
        .vram_address                (vram_address),
        .vram_valid                  (vram_valid),
        .vram_rdata                  (vram_rdata),
        .display_color               (display_color),
        .horizontal_offset_l         (horizontal_offset_l),
        .reg_screen_mode             (reg_screen_mode),
        .reg_display_on              (reg_display_on),
        .reg_pattern_name_table_base (reg_pattern_name_table_base),
        .reg_backdrop_color          (reg_backdrop_color)
    );

`ifdef VDP_G4567_HSCROLL_EN
    localparam bit SCROLL_ON = 1'b1;
`else
    localparam bit SCROLL_ON = 1'b0;
`endif
    localparam int NO_RST = 100000;

    typedef struct {
        logic        v;
        logic [16:0] a;
        logic [7:0]  c;
    } exp_t;

    exp_t        expq[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          req_count   = 0;

    // reference model state: words as returned by VRAM for pending / current / previous group
    logic [31:0] m_pend [2];
    logic [31:0] m_cur  [2];
    logic [31:0] m_prev [2];
    int          m_req_addr [2];
    logic [31:0] vram_mem [int];

    // scenario configuration, applied to the DUT inputs at each clock
    logic [4:0]  cfg_mode;
    bit          cfg_vact, cfg_don, cfg_ramp, cfg_mix;
    logic [2:0]  cfg_off;
    logic [7:0]  cfg_bd;
    logic [6:0]  cfg_base;
    int          cfg_rst_sx;
    int          rst_left = 0;
    logic [4:0]  mode_tab [5] = '{5'b01100, 5'b10000, 5'b10100, 5'b11100, 5'b11000};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    function automatic int mode_kind(input logic [4:0] m);
        case (m)
            5'b01100: return 4;
            5'b10000: return 5;
            5'b10100: return 6;
            5'b11100: return 7;
            default:  return 0;
        endcase
    endfunction

    // Element idx of a group stored as a left-to-right bit stream, bpp bits per element.
    function automatic int pick(input logic [31:0] w0, input logic [31:0] w1, input int idx, input int bpp);
        int bitpos, n, b;
        bitpos = idx * bpp;
        n      = bitpos / 8;
        b      = (n < 4) ? int'((w0 >> (8 * n)) & 32'hFF) : int'((w1 >> (8 * (n - 4))) & 32'hFF);
        return (b >> (8 - bpp - (bitpos % 8))) & ((1 << bpp) - 1);
    endfunction

    function automatic logic [31:0] vram_word(input int addr);
        if (!vram_mem.exists(addr)) vram_mem[addr] = $urandom;
        return vram_mem[addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = '0;
            m_cur[i]  = '0;
            m_prev[i] = '0;
        end
    endtask

    task automatic step(input int sx, input int y);
        int   px, p, kind, slot, g, off, e, i, grp, idx, bpp;
        exp_t ex;
        @(negedge clk);
        if (cfg_mix && $urandom_range(0, 96) == 0) begin
            cfg_mode = mode_tab[$urandom_range(0, 4)];
            cfg_don  = ($urandom_range(0, 3) != 0);
            cfg_vact = ($urandom_range(0, 3) != 0);
            cfg_off  = 3'($urandom_range(0, 7));
        end
        px = (sx >>> 3) & 511;
        p  = sx & 63;
        screen_pos_x                = 13'(sx);
        pixel_pos_x                 = 9'(px);
        pixel_pos_y                 = 8'(y);
        screen_v_active             = cfg_vact;
        reg_screen_mode             = cfg_mode;
        reg_display_on              = cfg_don;
        horizontal_offset_l         = cfg_off;
        reg_backdrop_color          = cfg_bd;
        reg_pattern_name_table_base = cfg_base;

        if (!reset_n && rst_left == 0) reset_n = 1'b1;
        if (sx == cfg_rst_sx) begin
            reset_n = 1'b0;
            #1;
            check("midline reset vram_valid", 32'(vram_valid), 32'd0);
            check("midline reset vram_address", 32'(vram_address), 32'd0);
            check("midline reset display_color", 32'(display_color), 32'd0);
            rst_left = 3;
        end
        if (!reset_n) begin
            ex.v = 1'b0; ex.a = '0; ex.c = '0;
            expq.push_back(ex);
            clear_model();
            rst_left--;
            return;
        end

        if (p == 32)      vram_rdata = cfg_ramp ? 32'h03020100 : vram_word(m_req_addr[0]);
        else if (p == 40) vram_rdata = cfg_ramp ? 32'h07060504 : vram_word(m_req_addr[1]);
        else              vram_rdata = $urandom;

        kind = mode_kind(cfg_mode);
        slot = (sx >>> 3) & 7;
        ex.v = 1'b0;
        ex.a = '0;
        if (cfg_vact && kind != 0 && (sx & 7) == 0 && (slot == 0 || (kind >= 6 && slot == 1))) begin
            g    = ((px >> 3) + 1) & 31;
            ex.v = 1'b1;
            if (kind >= 6)
                ex.a = 17'(int'(cfg_base[6]) * 65536 + y * 256 + g * 8 + slot * 4);
            else
                ex.a = 17'(int'(cfg_base[6:5]) * 32768 + y * 128 + g * 4);
            m_req_addr[slot] = int'(ex.a);
        end

        if (!cfg_vact || !cfg_don || px >= 256 || kind == 0) begin
            ex.c = cfg_bd;
        end else begin
            off = SCROLL_ON ? int'(cfg_off) : 0;
            e   = 8 + (px & 7) - off;
            if (kind == 5 || kind == 6) begin
                i   = 2 * e + ((sx >>> 2) & 1);
                grp = i / 16;
                idx = i % 16;
                bpp = (kind == 5) ? 2 : 4;
            end else begin
                grp = e / 8;
                idx = e % 8;
                bpp = (kind == 4) ? 4 : 8;
            end
            ex.c = grp != 0 ? 8'(pick(m_cur[0], m_cur[1], idx, bpp))
                            : 8'(pick(m_prev[0], m_prev[1], idx, bpp));
        end
        expq.push_back(ex);

        if (p == 32) m_pend[0] = vram_rdata;
        if (p == 40) m_pend[1] = vram_rdata;
        if (p == 63) begin
            m_prev = m_cur;
            m_cur  = m_pend;
        end
    endtask

    task automatic run(input logic [4:0] mode, input bit vact, input bit don, input int off,
                       input logic [7:0] bd, input bit ramp, input bit mix, input int lines,
                       input int rst_sx);
        cfg_mode   = mode;
        cfg_vact   = vact;
        cfg_don    = don;
        cfg_off    = 3'(off);
        cfg_bd     = bd;
        cfg_ramp   = ramp;
        cfg_mix    = mix;
        cfg_base   = 7'($urandom);
        cfg_rst_sx = rst_sx;
        for (int l = 0; l < lines; l++) begin
            int y;
            y = $urandom_range(0, 255);
            for (int sx = -256; sx < 2480; sx++) step(sx, y);
        end
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                ex = expq.pop_front();
                check("vram_valid", 32'(vram_valid), 32'(ex.v));
                check("display_color", 32'(display_color), 32'(ex.c));
                if (ex.v) begin
                    req_count++;
                    check("vram_address", 32'(vram_address), 32'(ex.a));
                    $display("req %0d: mode=%b addr=%05h expected %05h", req_count, reg_screen_mode,
                             vram_address, ex.a);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset_n                     = 1'b0;
        screen_pos_x                = '0;
        pixel_pos_x                 = '0;
        pixel_pos_y                 = '0;
        screen_v_active             = 1'b0;
        vram_rdata                  = '0;
        horizontal_offset_l         = '0;
        reg_screen_mode             = '0;
        reg_display_on              = 1'b0;
        reg_pattern_name_table_base = '0;
        reg_backdrop_color          = 8'h5A;
        clear_model();
        m_req_addr[0] = 0;
        m_req_addr[1] = 0;
        repeat (3) @(negedge clk);
        check("reset vram_valid", 32'(vram_valid), 32'd0);
        check("reset vram_address", 32'(vram_address), 32'd0);
        check("reset display_color", 32'(display_color), 32'd0);
        reset_n = 1'b1;

        run(5'b01100, 1'b0, 1'b1, 0, 8'hF4, 1'b0, 1'b0, 2, NO_RST);       // G4 inactive lines
        run(5'b01100, 1'b1, 1'b1, 0, 8'($urandom), 1'b0, 1'b0, 1, NO_RST);
        run(5'b01100, 1'b1, 1'b1, 7, 8'($urandom), 1'b0, 1'b0, 1, NO_RST);
        run(5'b10000, 1'b1, 1'b1, $urandom_range(0, 7), 8'($urandom), 1'b0, 1'b0, 1, NO_RST);
        run(5'b10100, 1'b1, 1'b1, $urandom_range(0, 7), 8'($urandom), 1'b0, 1'b0, 1, 700);
        run(5'b11100, 1'b1, 1'b1, 0, 8'($urandom), 1'b1, 1'b0, 1, NO_RST);  // ramp 0..7
        run(5'b11100, 1'b1, 1'b1, 3, 8'($urandom), 1'b1, 1'b0, 1, NO_RST);  // ramp with scroll 3
        run(5'b01100, 1'b1, 1'b1, 3, 8'($urandom), 1'b0, 1'b0, 1, NO_RST);
        run(5'b11100, 1'b1, 1'b0, 0, 8'($urandom), 1'b1, 1'b0, 1, NO_RST);  // display off
        run(5'b00100, 1'b1, 1'b1, 0, 8'($urandom), 1'b0, 1'b0, 1, NO_RST);  // unsupported mode
        run(5'b10100, 1'b1, 1'b1, 2, 8'($urandom), 1'b0, 1'b1, 3, NO_RST);  // random register churn

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
